// File: rtl/y86_pipe_skid.sv
// Two-entry skid buffer between Y86 pipeline stages. out_* comes straight from the main register.
// in_ready is registered. Define Y86_PIPE_STALL_CNT_EN to add the saturating stall_cnt counter.
module y86_pipe_skid #(
  parameter int              WIDTH      = 32,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = '0
`ifdef Y86_PIPE_STALL_CNT_EN
  , parameter int            CNT_W      = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef Y86_PIPE_STALL_CNT_EN
  , output logic [CNT_W-1:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} stateT;

  stateT            state, stateNext;
  logic [WIDTH-1:0] mainData, mainDataNext;
  logic [WIDTH-1:0] skidData, skidDataNext;
  logic             mainValid, skidValid;
  logic             inXfer, outXfer;

  assign out_valid = mainValid;
  assign out_data  = mainData;
  assign in_ready  = ~skidValid;

  assign inXfer  = in_valid & ~skidValid;
  assign outXfer = mainValid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= EMPTY;
      mainData  <= BUBBLE_VAL;
      skidData  <= BUBBLE_VAL;
      mainValid <= 1'b0;
      skidValid <= 1'b0;
    end else begin
      state     <= stateNext;
      mainData  <= mainDataNext;
      skidData  <= skidDataNext;
      mainValid <= (stateNext != EMPTY);
      skidValid <= (stateNext == FULL);
    end
  end

  always_comb begin
    stateNext    = state;
    mainDataNext = mainData;
    skidDataNext = skidData;
    if (flush) begin
      // Flush squashes everything, including a transfer offered this cycle.
      stateNext    = EMPTY;
      mainDataNext = BUBBLE_VAL;
      skidDataNext = BUBBLE_VAL;
    end else begin
      case (state)
        EMPTY: begin
          if (inXfer) begin
            mainDataNext = in_data;
            stateNext    = ONE;
          end
        end
        ONE: begin
          if (inXfer && outXfer) begin
            mainDataNext = in_data;
          end else if (inXfer) begin
            skidDataNext = in_data;
            stateNext    = FULL;
          end else if (outXfer) begin
            stateNext = EMPTY;
          end
        end
        FULL: begin
          if (outXfer) begin
            mainDataNext = skidData;
            stateNext    = ONE;
          end
        end
        default: stateNext = EMPTY;
      endcase
    end
  end

`ifdef Y86_PIPE_STALL_CNT_EN
  logic [CNT_W-1:0] stallCnt;

  assign stall_cnt = stallCnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stallCnt <= '0;
    end else if (mainValid && !out_ready && (stallCnt != {CNT_W{1'b1}})) begin
      stallCnt <= stallCnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_y86_pipe_skid.sv
// Directed and random checks for y86_pipe_skid; the counter test runs only with Y86_PIPE_STALL_CNT_EN.
module tb_y86_pipe_skid;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
`ifdef Y86_PIPE_STALL_CNT_EN
  logic [3:0]  stall_cnt;
`endif

  int passCnt = 0;
  int totalCnt = 0;

  always #5 clk = ~clk;

`ifdef Y86_PIPE_STALL_CNT_EN
  y86_pipe_skid #(.WIDTH(32), .BUBBLE_VAL(32'h0), .CNT_W(4)) dut (
`else
  y86_pipe_skid #(.WIDTH(32), .BUBBLE_VAL(32'h0)) dut (
`endif
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef Y86_PIPE_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
    #2;
    totalCnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", out_valid); else passCnt++;
    totalCnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b want 1", in_ready); else passCnt++;
    totalCnt++;
    if (out_data !== 32'h0) $display("FAIL reset_out_data got %h want 0", out_data); else passCnt++;
`ifdef Y86_PIPE_STALL_CNT_EN
    totalCnt++;
    if (stall_cnt !== 4'd0) $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); else passCnt++;
`endif
    @(negedge clk);
    rst = 1'b1;
    cyc();
    $display("reset: done");
  endtask

  task automatic test_streaming();
    logic [31:0] vals [3];
    vals = '{32'h11, 32'h22, 32'h33};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = vals[i];
      cyc();
      totalCnt++;
      if (out_valid !== 1'b1 || out_data !== vals[i])
        $display("FAIL stream_%0d got v=%0b d=%h want v=1 d=%h", i, out_valid, out_data, vals[i]);
      else passCnt++;
      totalCnt++;
      if (in_ready !== 1'b1) $display("FAIL stream_ready_%0d got %0b want 1", i, in_ready); else passCnt++;
      $display("stream: in=%h out=%h", vals[i], out_data);
    end
    in_valid = 1'b0;
    cyc();
    totalCnt++;
    if (out_valid !== 1'b0) $display("FAIL stream_drain got %0b want 0", out_valid); else passCnt++;
  endtask

  task automatic fill_ab();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA;
    cyc();
    totalCnt++;
    if (out_valid !== 1'b1 || out_data !== 32'hA || in_ready !== 1'b1)
      $display("FAIL fill_a got v=%0b d=%h r=%0b want 1 a 1", out_valid, out_data, in_ready);
    else passCnt++;
    in_data = 32'hB;
    cyc();
    in_valid = 1'b0;
    totalCnt++;
    if (in_ready !== 1'b0 || out_data !== 32'hA)
      $display("FAIL fill_full got r=%0b d=%h want 0 a", in_ready, out_data);
    else passCnt++;
  endtask

  task automatic test_backpressure();
    fill_ab();
    cyc();
    totalCnt++;
    if (in_ready !== 1'b0 || out_data !== 32'hA)
      $display("FAIL bp_hold got r=%0b d=%h want 0 a", in_ready, out_data);
    else passCnt++;
    out_ready = 1'b1;
    cyc();
    totalCnt++;
    if (out_valid !== 1'b1 || out_data !== 32'hB || in_ready !== 1'b1)
      $display("FAIL bp_second got v=%0b d=%h r=%0b want 1 b 1", out_valid, out_data, in_ready);
    else passCnt++;
    cyc();
    totalCnt++;
    if (out_valid !== 1'b0) $display("FAIL bp_empty got %0b want 0", out_valid); else passCnt++;
    $display("backpressure: A,B delivered");
  endtask

  task automatic test_flush();
    fill_ab();
    flush = 1'b1; in_valid = 1'b1; in_data = 32'hC;
    cyc();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    totalCnt++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1)
      $display("FAIL flush got v=%0b d=%h r=%0b want 0 0 1", out_valid, out_data, in_ready);
    else passCnt++;
    for (int i = 0; i < 3; i++) begin
      cyc();
      totalCnt++;
      if (out_valid !== 1'b0) $display("FAIL flush_no_c_%0d got v=%0b d=%h want v=0", i, out_valid, out_data);
      else passCnt++;
    end
    $display("flush: C discarded");
  endtask

  task automatic test_async_reset();
    fill_ab();
    #2;
    rst = 1'b0;
    #1;
    totalCnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0)
      $display("FAIL async_reset got v=%0b r=%0b d=%h want 0 1 0", out_valid, in_ready, out_data);
    else passCnt++;
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1; in_data = 32'h5; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    totalCnt++;
    if (out_valid !== 1'b1 || out_data !== 32'h5)
      $display("FAIL async_push got v=%0b d=%h want 1 5", out_valid, out_data);
    else passCnt++;
    cyc();
    totalCnt++;
    if (out_valid !== 1'b0) $display("FAIL async_drain got %0b want 0", out_valid); else passCnt++;
    $display("async_reset: 5 delivered after release");
  endtask

`ifdef Y86_PIPE_STALL_CNT_EN
  task automatic test_counter();
    rst = 1'b0;
    #1;
    rst = 1'b1;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h77;
    cyc();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
    totalCnt++;
    if (stall_cnt !== 4'd5) $display("FAIL cnt_5 got %0d want 5", stall_cnt); else passCnt++;
    for (int i = 0; i < 15; i++) cyc();
    totalCnt++;
    if (stall_cnt !== 4'd15) $display("FAIL cnt_sat got %0d want 15", stall_cnt); else passCnt++;
    for (int i = 0; i < 3; i++) cyc();
    totalCnt++;
    if (stall_cnt !== 4'd15) $display("FAIL cnt_hold got %0d want 15", stall_cnt); else passCnt++;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    totalCnt++;
    if (stall_cnt !== 4'd15) $display("FAIL cnt_flush got %0d want 15", stall_cnt); else passCnt++;
    $display("counter: saturated at %0d", stall_cnt);
  endtask
`endif

  task automatic test_random();
    logic [31:0] model [$];
    int nOut = 0;
    int nFail = 0;
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (out_valid && out_ready) begin
        totalCnt++;
        if (model.size() == 0) begin
          nFail++;
          if (nFail <= 10) $display("FAIL rand_extra cycle %0d got %h want no output", c, out_data);
        end else begin
          if (out_data !== model[0]) begin
            nFail++;
            if (nFail <= 10) $display("FAIL rand_order cycle %0d got %h want %h", c, out_data, model[0]);
          end else passCnt++;
          void'(model.pop_front());
        end
        nOut++;
      end
      if (in_valid && in_ready) model.push_back(in_data);
      cyc();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (out_valid) begin
        totalCnt++;
        if (model.size() == 0 || out_data !== model[0])
          $display("FAIL rand_tail got %h", out_data);
        else passCnt++;
        if (model.size() != 0) void'(model.pop_front());
      end
      cyc();
    end
    totalCnt++;
    if (model.size() != 0) $display("FAIL rand_lost got %0d left want 0", model.size()); else passCnt++;
    $display("random: %0d outputs checked", nOut);
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_async_reset();
`ifdef Y86_PIPE_STALL_CNT_EN
    test_counter();
`endif
    test_random();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
